// File: rtl/i3c_sdr_tx_framer_if.sv
// Byte handshake, SCL tick/abort control and serializer strobe bundle for the I3C SDR TX framer.
// The framer uses the slave modport; the byte source and tick generator use the master modport.
interface i3c_sdr_tx_framer_if #(
  parameter int DATA_W = 8
);
  localparam int FRAME_W = DATA_W + 1;

  // Handshake: a byte (byte_i, last_i) transfers on the cycle where byte_valid_i && byte_ready_o;
  // while valid is high without ready, byte_i/last_i must stay stable and valid must not drop.
  logic [DATA_W-1:0]  byte_i;
  logic               last_i;
  logic               byte_valid_i;
  logic               byte_ready_o;
  logic               bit_tick_i;
  logic               abort_i;
  logic               ser_load_o;
  logic               ser_enable_o;
  logic [FRAME_W-1:0] ser_data_o;
  logic               busy_o;
  logic               done_o;
  logic [1:0]         state_dbg_o;

  modport master (
    output byte_i,
    output last_i,
    output byte_valid_i,
    output bit_tick_i,
    output abort_i,
    input  byte_ready_o,
    input  ser_load_o,
    input  ser_enable_o,
    input  ser_data_o,
    input  busy_o,
    input  done_o,
    input  state_dbg_o
  );

  modport slave (
    input  byte_i,
    input  last_i,
    input  byte_valid_i,
    input  bit_tick_i,
    input  abort_i,
    output byte_ready_o,
    output ser_load_o,
    output ser_enable_o,
    output ser_data_o,
    output busy_o,
    output done_o,
    output state_dbg_o
  );
endinterface

// File: rtl/i3c_sdr_tx_framer.sv
// I3C SDR transmit framer: bit-reversed byte plus T-bit, load/shift strobes paced by bit_tick_i.
// Define I3C_TX_TBIT_PARITY_EN for odd-parity T-bit (controller write); default T-bit = ~last_i.
module i3c_sdr_tx_framer #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i3c_sdr_tx_framer_if.slave    bus
);
  localparam int FRAME_W = DATA_W + 1;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               last_q, last_d;
  logic               pend_q, pend_d;
  logic               done_q, done_d;

  logic [FRAME_W-1:0] frame_new;
  logic               final_bit;
  logic               ready;
  logic               accept;
  logic               load;
  logic               enable;

  // Serializer shifts LSB first, so the payload is reversed to put the byte MSB on the wire first.
  always_comb begin
    frame_new = '0;
    for (int i = 0; i < DATA_W; i++) begin
      frame_new[i] = bus.byte_i[DATA_W-1-i];
    end
`ifdef I3C_TX_TBIT_PARITY_EN
    frame_new[DATA_W] = ~^bus.byte_i;
`else
    frame_new[DATA_W] = ~bus.last_i;
`endif
  end

  assign final_bit = (state_q == S_SHIFT) && (cnt_q == CNT_MAX);
  // A byte taken during the T-bit without a tick is parked in pend_q until that tick arrives.
  assign ready     = !bus.abort_i && ((state_q == S_IDLE) || (final_bit && !pend_q));
  assign accept    = bus.byte_valid_i && ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    last_d  = last_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    load    = 1'b0;
    enable  = 1'b0;

    if (bus.abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            frame_d = frame_new;
            last_d  = bus.last_i;
            state_d = S_LOAD;
          end
        end

        S_LOAD: begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end

        S_SHIFT: begin
          if (cnt_q != CNT_MAX) begin
            if (bus.bit_tick_i) begin
              enable = 1'b1;
              cnt_d  = cnt_q + CNT_W'(1);
            end
          end else begin
            if (accept) begin
              frame_d = frame_new;
              last_d  = bus.last_i;
            end
            if (bus.bit_tick_i) begin
              cnt_d = '0;
              if (accept || pend_q) begin
                // Next frame loads straight after the T-bit: no enable, no idle bit.
                pend_d  = 1'b0;
                state_d = S_LOAD;
              end else begin
                enable  = 1'b1;
                done_d  = last_q;
                state_d = S_IDLE;
              end
            end else if (accept) begin
              pend_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  assign bus.byte_ready_o = ready;
  assign bus.ser_load_o   = load;
  assign bus.ser_enable_o = enable;
  assign bus.ser_data_o   = frame_q;
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.done_o       = done_q;
  assign bus.state_dbg_o  = state_q;

endmodule

// File: tb/tb_i3c_sdr_tx_framer.sv
// Self-checking bench for i3c_sdr_tx_framer: vector table of single frames plus
// back-to-back, abort and mid-frame reset sequences, with a frame scoreboard.
module tb_i3c_sdr_tx_framer;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = DATA_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               last;
    logic [FRAME_W-1:0] exp_frame;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i3c_sdr_tx_framer_if #(.DATA_W(DATA_W)) bus();

  i3c_sdr_tx_framer #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [FRAME_W-1:0] exp_q[$];
  int n_en = 0;
  int n_load = 0;
  int n_done = 0;
  bit acc;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs are applied at the negedge, outputs sampled 2ns later, then the edge.
  task automatic cyc(input bit tick);
    logic [FRAME_W-1:0] e;
    bus.bit_tick_i = tick;
    #2;
    acc = bus.byte_valid_i && bus.byte_ready_o;
    if (bus.ser_enable_o) n_en++;
    if (bus.done_o) n_done++;
    if (bus.ser_load_o) begin
      n_load++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ser_load_unexpected actual=%0h required=none", bus.ser_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("ser_data", bus.ser_data_o, e);
      end
    end
    @(posedge clk);
    #1;
    if (acc) bus.byte_valid_i = 1'b0;
    bus.bit_tick_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic offer(input logic [DATA_W-1:0] d, input logic l, input logic [FRAME_W-1:0] e);
    exp_q.push_back(e);
    bus.byte_i       = d;
    bus.last_i       = l;
    bus.byte_valid_i = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int en0, ld0, dn0;
    en0 = n_en; ld0 = n_load; dn0 = n_done;
    offer(v.data, v.last, v.exp_frame);
    cyc(1'b0);
    chk($sformatf("v%0d_accept", idx), {31'd0, acc}, 32'd1);
    chk($sformatf("v%0d_load_latency", idx), {31'd0, bus.ser_load_o}, 32'd1);
    chk($sformatf("v%0d_busy", idx), {31'd0, bus.busy_o}, 32'd1);
    cyc(1'b0);
    ticks(FRAME_W);
    chk($sformatf("v%0d_enables", idx), n_en - en0, FRAME_W);
    chk($sformatf("v%0d_loads", idx), n_load - ld0, 32'd1);
    chk($sformatf("v%0d_done", idx), n_done - dn0, {31'd0, v.last});
    chk($sformatf("v%0d_idle", idx), {31'd0, bus.busy_o}, 32'd0);
    chk($sformatf("v%0d_ready", idx), {31'd0, bus.byte_ready_o}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, ld0, dn0;
`ifdef I3C_TX_TBIT_PARITY_EN
    vecs[0] = '{8'h01, 1'b1, 9'h080};
    vecs[1] = '{8'h00, 1'b1, 9'h100};
    vecs[2] = '{8'hFF, 1'b0, 9'h1FF};
    vecs[3] = '{8'h03, 1'b1, 9'h1C0};
    vecs[4] = '{8'h12, 1'b0, 9'h148};
    vecs[5] = '{8'hA5, 1'b1, 9'h1A5};
`else
    vecs[0] = '{8'h01, 1'b1, 9'h080};
    vecs[1] = '{8'h01, 1'b0, 9'h180};
    vecs[2] = '{8'h00, 1'b1, 9'h000};
    vecs[3] = '{8'hFF, 1'b0, 9'h1FF};
    vecs[4] = '{8'h03, 1'b1, 9'h0C0};
    vecs[5] = '{8'h12, 1'b0, 9'h148};
`endif
    rst_n            = 1'b0;
    bus.byte_i       = '0;
    bus.last_i       = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.bit_tick_i   = 1'b0;
    bus.abort_i      = 1'b0;

    #12;
    chk("rst_load", {31'd0, bus.ser_load_o}, 32'd0);
    chk("rst_enable", {31'd0, bus.ser_enable_o}, 32'd0);
    chk("rst_data", {23'd0, bus.ser_data_o}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_done", {31'd0, bus.done_o}, 32'd0);
    chk("rst_ready", {31'd0, bus.byte_ready_o}, 32'd1);
    chk("rst_state", {30'd0, bus.state_dbg_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0);

    for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

    // Back-to-back: second byte waits with valid high and loads right after frame one's T-bit.
    en0 = n_en; ld0 = n_load; dn0 = n_done;
`ifdef I3C_TX_TBIT_PARITY_EN
    offer(8'h03, 1'b0, 9'h1C0);
`else
    offer(8'h03, 1'b0, 9'h1C0);
`endif
    cyc(1'b0);
`ifdef I3C_TX_TBIT_PARITY_EN
    offer(8'hFF, 1'b1, 9'h1FF);
`else
    offer(8'hFF, 1'b1, 9'h0FF);
`endif
    cyc(1'b0);
    ticks(FRAME_W - 1);
    chk("b2b_second_accepted", {31'd0, bus.byte_valid_i}, 32'd0);
    chk("b2b_frame1_enables", n_en - en0, FRAME_W - 1);
    cyc(1'b1);
    chk("b2b_final_tick_no_enable", n_en - en0, FRAME_W - 1);
    chk("b2b_load_next", {31'd0, bus.ser_load_o}, 32'd1);
    cyc(1'b0);
    ticks(FRAME_W);
    chk("b2b_total_enables", n_en - en0, 2 * FRAME_W - 1);
    chk("b2b_loads", n_load - ld0, 32'd2);
    chk("b2b_done_once", n_done - dn0, 32'd1);
    chk("b2b_idle", {31'd0, bus.busy_o}, 32'd0);

    // Abort on the 4th tick of a frame.
    en0 = n_en; dn0 = n_done;
`ifdef I3C_TX_TBIT_PARITY_EN
    offer(8'h5A, 1'b1, 9'h15A);
`else
    offer(8'h5A, 1'b1, 9'h05A);
`endif
    cyc(1'b0);
    cyc(1'b0);
    ticks(3);
    bus.abort_i    = 1'b1;
    bus.bit_tick_i = 1'b1;
    #1;
    chk("abort_no_enable", {31'd0, bus.ser_enable_o}, 32'd0);
    chk("abort_ready_gated", {31'd0, bus.byte_ready_o}, 32'd0);
    cyc(1'b1);
    bus.abort_i = 1'b0;
    #1;
    chk("abort_idle", {31'd0, bus.busy_o}, 32'd0);
    chk("abort_ready", {31'd0, bus.byte_ready_o}, 32'd1);
    chk("abort_data_held", {23'd0, bus.ser_data_o}, {23'd0, vecs[0].exp_frame ^ vecs[0].exp_frame ^ dut_hold_expected()});
    ticks(6);
    chk("abort_enables", n_en - en0, 32'd3);
    chk("abort_no_done", n_done - dn0, 32'd0);

    // Asynchronous reset in the middle of a SHIFT.
    en0 = n_en; ld0 = n_load; dn0 = n_done;
`ifdef I3C_TX_TBIT_PARITY_EN
    offer(8'h12, 1'b1, 9'h148);
`else
    offer(8'h12, 1'b1, 9'h048);
`endif
    cyc(1'b0);
    cyc(1'b0);
    ticks(2);
    bus.bit_tick_i = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_load", {31'd0, bus.ser_load_o}, 32'd0);
    chk("arst_enable", {31'd0, bus.ser_enable_o}, 32'd0);
    chk("arst_data", {23'd0, bus.ser_data_o}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("arst_ready", {31'd0, bus.byte_ready_o}, 32'd1);
    bus.bit_tick_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en0 = n_en;
    ticks(6);
    chk("arst_ticks_ignored", n_en - en0, 32'd0);
    chk("arst_no_reload", n_load - ld0, 32'd1);
    chk("arst_no_done", n_done - dn0, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [FRAME_W-1:0] dut_hold_expected();
`ifdef I3C_TX_TBIT_PARITY_EN
    return 9'h15A;
`else
    return 9'h05A;
`endif
  endfunction

endmodule
